// File: rtl/seg7_temp_scan.sv
// Four-slot multiplexed seven-segment driver rendering "TU°C" from frame-latched shadow copies of Uni/Dec.
// Optional build macro: LEADING_ZERO_BLANK_EN darkens the tens slot when the latched tens digit is zero.
module seg7_temp_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Uni,
    input  logic [1:0] Dec,
    input  logic       upd,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        SLOT_TENS  = 2'd0,
        SLOT_UNITS = 2'd1,
        SLOT_DEG   = 2'd2,
        SLOT_C     = 2'd3
    } slot_t;

    logic [CW-1:0] cnt_q, cnt_d;
    slot_t         idx_q, idx_d;
    logic          pending_q, pending_d;
    logic [4:0]    units_q, units_d;
    logic [1:0]    tens_q, tens_d;
    logic          cap_q, cap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q;
    logic          dp_q;
    logic          tick_s;

    function automatic logic [6:0] digit_glyph(input logic [4:0] v);
        logic [6:0] g;
        case (v)
            5'd0:    g = 7'b1000000;
            5'd1:    g = 7'b1111001;
            5'd2:    g = 7'b0100100;
            5'd3:    g = 7'b0110000;
            5'd4:    g = 7'b0011001;
            5'd5:    g = 7'b0010010;
            5'd6:    g = 7'b0000010;
            5'd7:    g = 7'b1111000;
            5'd8:    g = 7'b0000000;
            5'd9:    g = 7'b0010000;
            default: g = 7'b0111111;
        endcase
        return g;
    endfunction

    // Prescaler, slot sequencing, capture of the pending update at the frame boundary.
    always_comb begin
        tick_s    = (cnt_q == CNT_MAX);
        cnt_d     = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
        idx_d     = tick_s ? slot_t'(idx_q + 2'd1) : idx_q;
        pending_d = pending_q | upd;
        units_d   = units_q;
        tens_d    = tens_q;
        cap_d     = 1'b0;
        if (tick_s && (idx_q == SLOT_C) && (pending_q || upd)) begin
            units_d   = Uni;
            tens_d    = Dec;
            pending_d = 1'b0;
            cap_d     = 1'b1;
        end else begin
            cap_d     = 1'b0;
        end
    end

    // Glyph and anode selection from the current slot and shadow values only.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        case (idx_q)
            SLOT_TENS: begin
                an_d  = 4'b0111;
                seg_d = digit_glyph({3'b000, tens_q});
`ifdef LEADING_ZERO_BLANK_EN
                if (tens_q == 2'd0) begin
                    an_d  = 4'b1111;
                    seg_d = 7'b1111111;
                end else begin
                    an_d  = 4'b0111;
                end
`endif
            end
            SLOT_UNITS: begin
                an_d  = 4'b1011;
                seg_d = digit_glyph(units_q);
            end
            SLOT_DEG: begin
                an_d  = 4'b1101;
                seg_d = 7'b0011100;
            end
            SLOT_C: begin
                an_d  = 4'b1110;
                seg_d = 7'b1000110;
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
            end
        endcase
    end

    // State and registered outputs; frame trails capture by one cycle so it lines up with the new tens slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= {CW{1'b0}};
            idx_q     <= SLOT_TENS;
            pending_q <= 1'b0;
            units_q   <= 5'd0;
            tens_q    <= 2'd0;
            cap_q     <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
            frame_q   <= 1'b0;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            units_q   <= units_d;
            tens_q    <= tens_d;
            cap_q     <= cap_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= cap_q;
            dp_q      <= 1'b1;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = dp_q;
    assign frame = frame_q;
endmodule
